// File: rtl/hps_ps2_pkg.sv
// Shared FSM encoding and width helper for the multi-channel PS/2 transmitter.
package hps_ps2_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 4'd0,
      ST_BIT0 = 4'd1,
      ST_BIT1 = 4'd2,
      ST_BIT2 = 4'd3,
      ST_BIT3 = 4'd4,
      ST_BIT4 = 4'd5,
      ST_BIT5 = 4'd6,
      ST_BIT6 = 4'd7,
      ST_BIT7 = 4'd8,
      ST_PAR  = 4'd9,
      ST_STOP = 4'd10,
      ST_DONE = 4'd11
   } state_e;

   function automatic int chan_w(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/hps_ps2_chan.sv
// One PS/2 transmit channel: byte FIFO plus frame shifter/FSM stepped by the shared tick.
module hps_ps2_chan
   import hps_ps2_pkg::*;
#(
   parameter int FIFO_BITS = 3
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       tick_i,
   input  logic       clk_ps2_i,
   input  logic       inhibit_i,
   input  logic       push_i,
   input  logic [7:0] push_data_i,
   output logic       full_o,
   output logic       drop_o,
   output logic       ps2_clk_o,
   output logic       ps2_data_o
);

   localparam int DEPTH = 1 << FIFO_BITS;
   localparam logic [FIFO_BITS:0] DEPTH_C = (FIFO_BITS + 1)'(DEPTH);

   logic [7:0]           mem_q [DEPTH];
   logic [FIFO_BITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [FIFO_BITS:0]   count_q, count_d;
   logic                 full_q;
   state_e               state_q, state_d;
   logic [7:0]           shift_q, shift_d;
   logic                 par_q, par_d, data_q, data_d;
   logic                 fifo_full, push_ok, pop;

   // Fullness is judged on the pre-pop count, so a same-cycle push and pop drops the byte.
   assign fifo_full = (count_q == DEPTH_C);
   assign push_ok   = push_i & ~fifo_full;
   assign drop_o    = push_i & fifo_full;

   // NOTE: FIFO storage carries no reset; only pointers and count define its contents.
   always_ff @(posedge clk_sys) begin
      if (push_ok) mem_q[wptr_q] <= push_data_i;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      par_d   = par_q;
      data_d  = data_q;
      pop     = 1'b0;
      if (tick_i) begin
         if (inhibit_i && (state_q >= ST_BIT0) && (state_q <= ST_PAR)) begin
            state_d = ST_IDLE;
            data_d  = 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if ((count_q != '0) && !inhibit_i) begin
                     shift_d = mem_q[rptr_q];
                     par_d   = 1'b1;
                     data_d  = 1'b0;
                     state_d = ST_BIT0;
                  end
               end
               ST_PAR: begin
                  data_d  = par_q;
                  state_d = ST_STOP;
               end
               ST_STOP: begin
                  data_d  = 1'b1;
                  state_d = ST_DONE;
               end
               ST_DONE: begin
                  pop     = 1'b1;
                  state_d = ST_IDLE;
               end
               default: begin
                  data_d  = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
                  par_d   = par_q ^ shift_q[0];
                  state_d = state_e'(state_q + STATE_W'(1));
               end
            endcase
         end
      end
      wptr_d  = wptr_q + FIFO_BITS'(push_ok);
      rptr_d  = rptr_q + FIFO_BITS'(pop);
      count_d = count_q + (FIFO_BITS + 1)'(push_ok) - (FIFO_BITS + 1)'(pop);
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         par_q   <= 1'b1;
         data_q  <= 1'b1;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         data_q  <= data_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
      end
   end

   assign full_o     = full_q;
   assign ps2_clk_o  = clk_ps2_i | (state_q == ST_IDLE);
   assign ps2_data_o = data_q;

endmodule

// File: rtl/hps_ps2_tx.sv
// Multi-channel PS/2 device-side transmitter: shared clock divider/tick, write decode, channels.
// Optional host-inhibit sensing on ps2_clk_in is enabled by defining HPS_PS2_INHIBIT_EN.
module hps_ps2_tx
   import hps_ps2_pkg::*;
#(
   parameter int CHANNELS  = 2,
   parameter int FIFO_BITS = 3,
   parameter int PS2DIV    = 1000
) (
   input  logic                          clk_sys,
   input  logic                          reset,
   input  logic                          wr,
   input  logic [chan_w(CHANNELS)-1:0]   wr_ch,
   input  logic [7:0]                    wr_data,
   output logic [CHANNELS-1:0]           full,
   output logic [CHANNELS-1:0]           overflow,
   input  logic                          ovf_clr,
   output logic [CHANNELS-1:0]           ps2_clk,
   output logic [CHANNELS-1:0]           ps2_data,
   input  logic [CHANNELS-1:0]           ps2_clk_in
);

   localparam int CW    = chan_w(CHANNELS);
   localparam int CNT_W = (PS2DIV > 0) ? $clog2(PS2DIV + 1) : 1;

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                clk_ps2_q, clk_ps2_d, tick_q, tick_d, wrap;
   logic [CHANNELS-1:0] overflow_q, overflow_d, drop, push, inhibit;

   always_comb begin
      wrap       = (cnt_q == CNT_W'(PS2DIV));
      cnt_d      = wrap ? '0 : cnt_q + CNT_W'(1);
      clk_ps2_d  = clk_ps2_q ^ wrap;
      tick_d     = wrap & ~clk_ps2_q;
      // A drop in the same cycle as a clear wins.
      overflow_d = (overflow_q & ~{CHANNELS{ovf_clr}}) | drop;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt_q      <= '0;
         clk_ps2_q  <= 1'b0;
         tick_q     <= 1'b0;
         overflow_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         clk_ps2_q  <= clk_ps2_d;
         tick_q     <= tick_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef HPS_PS2_INHIBIT_EN
   logic [CHANNELS-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= ps2_clk_in;
         sync2_q <= sync1_q;
      end
   end

   assign inhibit = ~sync2_q;
`else
   logic unused_inhibit;
   assign unused_inhibit = &ps2_clk_in;
   assign inhibit        = '0;
`endif

   assign overflow = overflow_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      assign push[i] = wr && (wr_ch == CW'(i));

      hps_ps2_chan #(
         .FIFO_BITS (FIFO_BITS)
      ) u_chan (
         .clk_sys     (clk_sys),
         .reset       (reset),
         .tick_i      (tick_q),
         .clk_ps2_i   (clk_ps2_q),
         .inhibit_i   (inhibit[i]),
         .push_i      (push[i]),
         .push_data_i (wr_data),
         .full_o      (full[i]),
         .drop_o      (drop[i]),
         .ps2_clk_o   (ps2_clk[i]),
         .ps2_data_o  (ps2_data[i])
      );
   end

endmodule

// File: tb/tb_hps_ps2_tx.sv
// Scoreboard bench for hps_ps2_tx: expected frame bits queued per channel, checked on each PS/2 clock fall.
module tb_hps_ps2_tx;

   localparam int CH    = 3;
   localparam int FB    = 3;
   localparam int DIV   = 4;
   localparam int DEPTH = 1 << FB;
   localparam int CW    = 2;

   logic          clk_sys = 1'b0;
   logic          reset, wr, ovf_clr;
   logic [CW-1:0] wr_ch;
   logic [7:0]    wr_data;
   logic [CH-1:0] full, overflow, ps2_clk, ps2_data, ps2_clk_in;

   int            checks = 0;
   int            errors = 0;
   bit            exp_q [CH][$];
   int            mcnt [CH];
   int            seen [CH];
   logic [CH-1:0] prev_clk = '1;
   bit            e_bit;

   always #5 clk_sys = ~clk_sys;

   hps_ps2_tx #(
      .CHANNELS  (CH),
      .FIFO_BITS (FB),
      .PS2DIV    (DIV)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .wr         (wr),
      .wr_ch      (wr_ch),
      .wr_data    (wr_data),
      .full       (full),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .ps2_clk_in (ps2_clk_in)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: start 0, data LSB first, odd parity, stop 1.
   function automatic void push_frame(input int ch, input logic [7:0] b);
      exp_q[ch].push_back(1'b0);
      for (int k = 0; k < 8; k++) exp_q[ch].push_back(b[k]);
      exp_q[ch].push_back(($countones(b) % 2) == 0);
      exp_q[ch].push_back(1'b1);
   endfunction

   // Monitor: the host samples data on every falling edge of the PS/2 clock.
   always @(negedge clk_sys) begin
      for (int i = 0; i < CH; i++) begin
         if (!reset && prev_clk[i] && !ps2_clk[i]) begin
            seen[i]++;
            if (exp_q[i].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_bit ch%0d: got %0b expected no frame", i, ps2_data[i]);
            end else begin
               e_bit = exp_q[i].pop_front();
               check($sformatf("frame_bit_ch%0d", i), 32'(ps2_data[i]), 32'(e_bit));
            end
         end
      end
      prev_clk <= ps2_clk;
   end

   task automatic do_wr(input int ch, input logic [7:0] d);
      @(negedge clk_sys);
      wr      = 1'b1;
      wr_ch   = ch[CW-1:0];
      wr_data = d;
      if (ch < CH && mcnt[ch] < DEPTH) begin
         push_frame(ch, d);
         mcnt[ch]++;
      end
   endtask

   task automatic wr_end();
      @(negedge clk_sys);
      wr = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (n < budget && (exp_q[0].size() != 0 || exp_q[1].size() != 0 ||
                            exp_q[2].size() != 0 || ps2_clk != '1)) begin
         @(negedge clk_sys);
         n++;
      end
      check("drain_in_time", 32'(n < budget), 32'd1);
      repeat (30) @(negedge clk_sys);
      check("idle_clk", 32'(ps2_clk), 32'(3'b111));
      check("idle_data", 32'(ps2_data), 32'(3'b111));
      for (int i = 0; i < CH; i++) mcnt[i] = 0;
   endtask

   task automatic wait_bits(input int ch, input int target, input int budget);
      int n = 0;
      while (n < budget && seen[ch] < target) begin
         @(negedge clk_sys);
         n++;
      end
      check("bits_in_time", 32'(seen[ch] >= target), 32'd1);
   endtask

   task automatic wait_level(input int ch, input logic lvl, input int budget);
      int n = 0;
      while (n < budget && ps2_clk[ch] !== lvl) begin
         @(negedge clk_sys);
         n++;
      end
      check("level_in_time", 32'(n < budget), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int burst, ch;
      reset      = 1'b1;
      wr         = 1'b0;
      wr_ch      = '0;
      wr_data    = '0;
      ovf_clr    = 1'b0;
      ps2_clk_in = '1;
      repeat (3) @(negedge clk_sys);
      check("rst_clk", 32'(ps2_clk), 32'(3'b111));
      check("rst_data", 32'(ps2_data), 32'(3'b111));
      check("rst_full", 32'(full), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      reset = 1'b0;

      // Single frame of 0xA5 on ch0.
      do_wr(0, 8'hA5);
      wr_end();
      wait_drain(1000);

      // Fill ch1, overflow, clear, drain in order.
      for (int k = 0; k < DEPTH; k++) do_wr(1, 8'($urandom));
      wr_end();
      check("full_after_fill", 32'(full), 32'(3'b010));
      do_wr(1, 8'h99);
      wr_end();
      check("ovf_on_drop", 32'(overflow), 32'(3'b010));
      check("full_held", 32'(full), 32'(3'b010));
      @(negedge clk_sys);
      ovf_clr = 1'b1;
      @(negedge clk_sys);
      ovf_clr = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      wait_drain(5000);
      check("full_drained", 32'(full), 32'd0);

      // Parallel frames on ch0/ch1 share ticks.
      do_wr(0, 8'h00);
      do_wr(1, 8'hFF);
      wr_end();
      for (int k = 0; k < 11; k++) begin
         wait_level(0, 1'b0, 60);
         check("parallel_clk", 32'(ps2_clk[1:0]), 32'd0);
         wait_level(0, 1'b1, 60);
      end
      wait_drain(1000);

      // Out-of-range channel is ignored.
      do_wr(3, 8'h55);
      wr_end();
      repeat (300) @(negedge clk_sys);
      check("bad_ch_ovf", 32'(overflow), 32'd0);
      check("bad_ch_full", 32'(full), 32'd0);
      check("bad_ch_idle", 32'(ps2_clk), 32'(3'b111));

      // Reset in the middle of a frame.
      do_wr(0, 8'($urandom));
      wr_end();
      wait_bits(0, seen[0] + 5, 400);
      @(negedge clk_sys);
      reset = 1'b1;
      @(negedge clk_sys);
      check("midrst_clk", 32'(ps2_clk), 32'(3'b111));
      check("midrst_data", 32'(ps2_data), 32'(3'b111));
      exp_q[0].delete();
      mcnt[0] = 0;
      reset = 1'b0;
      repeat (300) @(negedge clk_sys);
      do_wr(0, 8'($urandom));
      wr_end();
      wait_drain(1000);

`ifdef HPS_PS2_INHIBIT_EN
      // Host inhibit at state 4 aborts; the whole byte is resent after release.
      do_wr(0, 8'h3C);
      wr_end();
      wait_bits(0, seen[0] + 4, 400);
      ps2_clk_in[0] = 1'b0;
      repeat (40) @(negedge clk_sys);
      check("inh_clk", 32'(ps2_clk[0]), 32'd1);
      check("inh_data", 32'(ps2_data[0]), 32'd1);
      exp_q[0].delete();
      push_frame(0, 8'h3C);
      repeat (60) @(negedge clk_sys);
      ps2_clk_in[0] = 1'b1;
      wait_drain(1000);
`endif

      // Randomised bursts, never deep enough to fill a FIFO.
      for (int r = 0; r < 6; r++) begin
         burst = $urandom_range(1, 4);
         for (int k = 0; k < burst; k++) begin
            ch = $urandom_range(0, 3);
            do_wr(ch, 8'($urandom));
         end
         wr_end();
         wait_drain(4000);
         check("rand_ovf", 32'(overflow), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
